// File: rtl/pop_eval_pkg.sv
// Shared definitions for the population evaluation sequencer: default
// geometry, FSM state encoding, the stale-done guard length and the
// watchdog limit used when POP_EVAL_TIMEOUT_EN is defined.
package pop_eval_pkg;

    localparam int DEF_POP_SIZE = 50;
    localparam int DEF_GENOME_W = 150;
    localparam int DEF_DIST_W   = 12;
    localparam int DEF_IDX_W    = 6;

    // WAIT cycles during which eval_done is ignored (stale done from last run)
    localparam int GUARD_CYCLES = 2;

    // Watchdog counter width and the count at which WAIT gives up
    localparam int              WAIT_CNT_W    = 16;
    localparam logic [15:0]     TIMEOUT_LIMIT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } pop_eval_state_e;

endpackage

// File: rtl/pop_eval_sequencer_min_tracker.sv
// pop_min_tracker: running unsigned minimum of a stream of (index, distance)
// pairs. A strictly smaller distance replaces the current best, so ties keep
// the earlier (lower) index. The clear strobe restarts from all-ones/index 0.
module pop_min_tracker #(
    parameter int IDX_W  = 6,
    parameter int DIST_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic [DIST_W-1:0] upd_dist,
    output logic [IDX_W-1:0]  best_idx,
    output logic [DIST_W-1:0] best_dist
);

    // Best-so-far register: cleared on strobe, replaced on strictly smaller
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_idx  <= '0;
            best_dist <= '1;
        end else if (clear) begin
            best_idx  <= '0;
            best_dist <= '1;
        end else if (upd_valid && (upd_dist < best_dist)) begin
            best_idx  <= upd_idx;
            best_dist <= upd_dist;
        end
    end

endmodule

// File: rtl/pop_eval_sequencer.sv
// pop_eval_sequencer: loads a population one genome per handshake, kicks the
// distance array, snapshots its packed results and streams them back out while
// tracking the minimum-distance individual.
// Optional build macro: POP_EVAL_TIMEOUT_EN adds a WAIT watchdog and the
// sticky timeout_err output.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid-side data holds stable while ready is low.
import pop_eval_pkg::*;

module pop_eval_sequencer #(
    parameter int POP_SIZE = DEF_POP_SIZE,
    parameter int GENOME_W = DEF_GENOME_W,
    parameter int DIST_W   = DEF_DIST_W,
    parameter int IDX_W    = DEF_IDX_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [GENOME_W-1:0]          in_genome,
    output logic                         eval_start,
    output logic [POP_SIZE*GENOME_W-1:0] eval_pop,
    input  logic                         eval_done,
    input  logic [POP_SIZE*DIST_W-1:0]   eval_dist,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             out_idx,
    output logic [DIST_W-1:0]            out_dist,
    output logic [IDX_W-1:0]             best_idx,
    output logic [DIST_W-1:0]            best_dist,
    output logic                         batch_done,
`ifdef POP_EVAL_TIMEOUT_EN
    output logic                         timeout_err,
`endif
    output pop_eval_state_e              state_dbg
);

    pop_eval_state_e          state, state_nxt;
    logic [IDX_W-1:0]         idx;
    logic [WAIT_CNT_W-1:0]    wait_cnt;
    logic [POP_SIZE*GENOME_W-1:0] pop_q;
    logic [POP_SIZE*DIST_W-1:0]   snap_q;

    logic last_idx;
    logic load_acc;
    logic capture;
    logic timeout_hit;
    logic drain_hs;

    assign last_idx = (idx == IDX_W'(POP_SIZE - 1));
    assign load_acc = (state == ST_LOAD) && in_valid;
    assign drain_hs = (state == ST_DRAIN) && out_ready;
    assign capture  = (state == ST_WAIT) && eval_done &&
                      (wait_cnt >= WAIT_CNT_W'(GUARD_CYCLES));
`ifdef POP_EVAL_TIMEOUT_EN
    assign timeout_hit = (state == ST_WAIT) && !capture && (wait_cnt == TIMEOUT_LIMIT);
`else
    assign timeout_hit = 1'b0;
`endif

    assign eval_pop  = pop_q;
    assign state_dbg = state;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_LOAD;
        else     state <= state_nxt;
    end

    // Next-state logic: LOAD -> START -> WAIT -> DRAIN -> LOAD
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:  if (load_acc && last_idx)     state_nxt = ST_START;
            ST_START:                               state_nxt = ST_WAIT;
            ST_WAIT:  if (capture || timeout_hit)   state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_hs && last_idx)     state_nxt = ST_LOAD;
            default:                                state_nxt = ST_LOAD;
        endcase
    end

    // Moore outputs; stream outputs read as zero outside DRAIN
    always_comb begin
        in_ready   = (state == ST_LOAD);
        eval_start = (state == ST_START);
        out_valid  = (state == ST_DRAIN);
        out_idx    = '0;
        out_dist   = '0;
        if (state == ST_DRAIN) begin
            out_idx  = idx;
            out_dist = snap_q[int'(idx)*DIST_W +: DIST_W];
        end
    end

    // Shared slot index: load position in LOAD, stream position in DRAIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (load_acc || drain_hs) begin
            idx <= last_idx ? '0 : idx + IDX_W'(1);
        end else if (capture || timeout_hit) begin
            idx <= '0;
        end
    end

    // WAIT cycle counter, saturating; restarts whenever WAIT is left
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      wait_cnt <= '0;
        else if (state != ST_WAIT)    wait_cnt <= '0;
        else if (wait_cnt != '1)      wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
    end

    // Population register: one genome slot written per accepted load
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           pop_q <= '0;
        else if (load_acc) pop_q[int'(idx)*GENOME_W +: GENOME_W] <= in_genome;
    end

    // Distance snapshot: taken once per run so the array may move on
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              snap_q <= '0;
        else if (capture)     snap_q <= eval_dist;
        else if (timeout_hit) snap_q <= '1;
    end

    // End-of-stream pulse, one cycle after the final handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) batch_done <= 1'b0;
        else     batch_done <= drain_hs && last_idx;
    end

`ifdef POP_EVAL_TIMEOUT_EN
    // Sticky watchdog flag, cleared when the next evaluation starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   timeout_err <= 1'b0;
        else if (state == ST_START) timeout_err <= 1'b0;
        else if (timeout_hit)      timeout_err <= 1'b1;
    end
`endif

    pop_min_tracker #(
        .IDX_W  (IDX_W),
        .DIST_W (DIST_W)
    ) u_min_tracker (
        .clk       (clk),
        .rst       (rst),
        .clear     (capture || timeout_hit),
        .upd_valid (drain_hs),
        .upd_idx   (idx),
        .upd_dist  (out_dist),
        .best_idx  (best_idx),
        .best_dist (best_dist)
    );

endmodule

// File: tb/tb_pop_eval_sequencer.sv
// Directed/randomized bench for pop_eval_sequencer: loads populations,
// drives the evaluator handshake, and checks the distance stream and the
// best-individual result against a reference model built from the rules.
module tb_pop_eval_sequencer;
  import pop_eval_pkg::*;

  localparam int P  = DEF_POP_SIZE;
  localparam int GW = DEF_GENOME_W;
  localparam int DW = DEF_DIST_W;
  localparam int IW = DEF_IDX_W;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [GW-1:0]     in_genome;
  logic              eval_start;
  logic [P*GW-1:0]   eval_pop;
  logic              eval_done;
  logic [P*DW-1:0]   eval_dist;
  logic              out_valid;
  logic              out_ready;
  logic [IW-1:0]     out_idx;
  logic [DW-1:0]     out_dist;
  logic [IW-1:0]     best_idx;
  logic [DW-1:0]     best_dist;
  logic              batch_done;
`ifdef POP_EVAL_TIMEOUT_EN
  logic              timeout_err;
`endif
  pop_eval_state_e   state_dbg;

  pop_eval_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_genome  (in_genome),
    .eval_start (eval_start),
    .eval_pop   (eval_pop),
    .eval_done  (eval_done),
    .eval_dist  (eval_dist),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_dist   (out_dist),
    .best_idx   (best_idx),
    .best_dist  (best_dist),
    .batch_done (batch_done),
`ifdef POP_EVAL_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=hang required=finish");
    $fatal(1, "simulation time limit");
  end

  // ---------------- model state / scoreboard ----------------
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [GW-1:0]    gen_m[P];
  logic [DW-1:0]    dist_m[P];
  logic [P*GW-1:0]  exp_pop;
  logic [DW-1:0]    exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [GW-1:0] rand_genome();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[GW-1:0];
  endfunction

  function automatic logic [P*DW-1:0] pack_dist();
    logic [P*DW-1:0] v;
    for (int i = 0; i < P; i++) v[i*DW +: DW] = dist_m[i];
    return v;
  endfunction

  // Best individual: smallest distance, earliest index among equals;
  // an all-ones minimum leaves the initial index 0.
  function automatic logic [DW-1:0] model_best_dist();
    logic [DW-1:0] m;
    m = '1;
    for (int i = 0; i < P; i++) if (dist_m[i] < m) m = dist_m[i];
    return m;
  endfunction

  function automatic logic [IW-1:0] model_best_idx();
    logic [DW-1:0] m;
    m = model_best_dist();
    for (int i = 0; i < P; i++) if (dist_m[i] == m) return IW'(i);
    return '0;
  endfunction

  // ---------------- driver tasks ----------------
  // Loads gen_m; returns in the START cycle. hold_valid keeps in_valid high.
  task automatic load_pop(input bit hold_valid);
    for (int i = 0; i < P; i++) exp_pop[i*GW +: GW] = gen_m[i];
    for (int i = 0; i < P; i++) begin
      in_valid  = 1'b1;
      in_genome = gen_m[i];
      check("in_ready_load", 64'(in_ready), 64'(1));
      tick();
    end
    in_genome = rand_genome();
    check("in_ready_after_load", 64'(in_ready), 64'(0));
    check("eval_start_pulse", 64'(eval_start), 64'(1));
    check("state_start", 64'(state_dbg), 64'(ST_START));
    check("eval_pop_slot7", 64'(eval_pop[7*GW +: 64]), 64'(gen_m[7]));
    check("eval_pop_all", 64'(eval_pop === exp_pop), 64'(1));
    if (!hold_valid) in_valid = 1'b0;
  endtask

  // From the START cycle through capture; returns in the first DRAIN cycle.
  task automatic eval_phase(input bit early, input int extra);
    eval_dist = pack_dist();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("guard_no_capture", 64'(out_valid), 64'(0));
      check("guard_start_low", 64'(eval_start), 64'(0));
      check("guard_in_ready", 64'(in_ready), 64'(0));
      check("guard_pop_stable", 64'(eval_pop === exp_pop), 64'(1));
    end
    in_valid = 1'b0;
    if (!early) begin
      for (int k = 0; k < extra; k++) begin
        tick();
        check("wait_no_done", 64'(out_valid), 64'(0));
      end
      eval_done = 1'b1;
    end
    tick();
    check("drain_entry", 64'(out_valid), 64'(1));
    check("drain_best_cleared_d", 64'(best_dist), 64'({DW{1'b1}}));
    check("drain_best_cleared_i", 64'(best_idx), 64'(0));
    eval_done = 1'b0;
    eval_dist = {P{12'(3)}} ^ pack_dist();
  endtask

  // Streams out the snapshot. mode 0: ready=1, 1: toggle, 2: random.
  // stop_at >= 0 returns early in the cycle presenting that index.
  task automatic drain(input int mode, input int stop_at);
    int exp_i;
    int cyc;
    bit hs;
    exp_q.delete();
    for (int i = 0; i < P; i++) exp_q.push_back(dist_m[i]);
    exp_i = 0;
    cyc   = 0;
    while (exp_i < P && cyc < 4*P + 20) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      check("stream_valid", 64'(out_valid), 64'(1));
      check("stream_idx", 64'(out_idx), 64'(exp_i));
      check("stream_dist", 64'(out_dist), 64'(exp_q[0]));
      check("stream_batch_low", 64'(batch_done), 64'(0));
      if (exp_i == stop_at) begin
        out_ready = 1'b0;
        return;
      end
      hs = out_ready;
      tick();
      cyc++;
      if (hs) begin
        exp_i++;
        void'(exp_q.pop_front());
      end
    end
    out_ready = 1'b0;
    check("stream_handshakes", 64'(exp_i), 64'(P));
    check("batch_done_pulse", 64'(batch_done), 64'(1));
    check("end_valid_low", 64'(out_valid), 64'(0));
    check("end_state_load", 64'(state_dbg), 64'(ST_LOAD));
    check("best_idx", 64'(best_idx), 64'(model_best_idx()));
    check("best_dist", 64'(best_dist), 64'(model_best_dist()));
    tick();
    check("batch_done_one_cycle", 64'(batch_done), 64'(0));
    check("best_idx_hold", 64'(best_idx), 64'(model_best_idx()));
    check("best_dist_hold", 64'(best_dist), 64'(model_best_dist()));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    check({tag, "_eval_start"}, 64'(eval_start), 64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_batch_done"}, 64'(batch_done), 64'(0));
    check({tag, "_out_idx"}, 64'(out_idx), 64'(0));
    check({tag, "_out_dist"}, 64'(out_dist), 64'(0));
    check({tag, "_best_idx"}, 64'(best_idx), 64'(0));
    check({tag, "_best_dist"}, 64'(best_dist), 64'({DW{1'b1}}));
    check({tag, "_state"}, 64'(state_dbg), 64'(ST_LOAD));
    check({tag, "_pop_zero"}, 64'(eval_pop === '0), 64'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_genome = '0;
    eval_done = 1'b0;
    eval_dist = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // A: genome i, dist 100+i, done held high early, in_valid held through WAIT
    for (int i = 0; i < P; i++) begin
      gen_m[i]  = GW'(i);
      dist_m[i] = DW'(100 + i);
    end
    eval_done = 1'b1;
    load_pop(1'b1);
    eval_phase(1'b1, 0);
    drain(0, -1);

    // B: two equal minima at 23 and 41, stalling stream
    for (int i = 0; i < P; i++) begin
      gen_m[i]  = rand_genome();
      dist_m[i] = DW'(500);
    end
    dist_m[23] = DW'(12);
    dist_m[41] = DW'(12);
    load_pop(1'b0);
    eval_phase(1'b0, 2);
    drain(1, -1);

    // C: all-equal distances
    begin
      logic [DW-1:0] v;
      v = DW'($urandom_range(0, 4000));
      for (int i = 0; i < P; i++) begin
        gen_m[i]  = rand_genome();
        dist_m[i] = v;
      end
    end
    load_pop(1'b0);
    eval_phase(1'b0, 0);
    drain(2, -1);

    // D: all-ones distances never displace the initial best
    for (int i = 0; i < P; i++) begin
      gen_m[i]  = rand_genome();
      dist_m[i] = '1;
    end
    load_pop(1'b0);
    eval_phase(1'b0, 1);
    drain(0, -1);

    // E: fully random runs
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < P; i++) begin
        gen_m[i]  = rand_genome();
        dist_m[i] = DW'($urandom);
      end
      load_pop(1'b0);
      eval_phase(1'b0, $urandom_range(0, 6));
      drain(2, -1);
    end

    // F: reset mid-DRAIN at index 20
    for (int i = 0; i < P; i++) begin
      gen_m[i]  = rand_genome();
      dist_m[i] = DW'($urandom);
    end
    load_pop(1'b0);
    eval_phase(1'b0, 0);
    drain(0, 20);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    rst = 1'b0;
    eval_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_stale_done", 64'(out_valid), 64'(0));
      check("post_rst_state", 64'(state_dbg), 64'(ST_LOAD));
    end

    // G: clean restart after reset, stale done still high
    for (int i = 0; i < P; i++) begin
      gen_m[i]  = rand_genome();
      dist_m[i] = DW'($urandom);
    end
    load_pop(1'b0);
    eval_phase(1'b1, 0);
    drain(2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
